// File: rtl/exam_eval_pkg.sv
// Shared types and helpers for the exam answer evaluator.
package exam_eval_pkg;

    // Evaluator sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Default width of a set index / answer field
    localparam int SET_W_DEFAULT = 3;

    // Set index meaning "no set assigned"
    localparam int UNASSIGNED = 0;

    // A set index is legal when it names one of the sets 1..q
    function automatic logic set_in_range(input int unsigned set, input int unsigned q);
        return (set != UNASSIGNED) && (set <= q);
    endfunction

endpackage

// File: rtl/exam_key_ram.sv
// Answer-key register file: Q sets x SLOTS slots x SET_W bits.
// Sets and slots are addressed 1-based; out-of-range writes are dropped
// and out-of-range reads return 0 (which never matches an answer).
module exam_key_ram
    import exam_eval_pkg::*;
#(
    parameter int Q     = 3,
    parameter int SLOTS = 3,
    parameter int SET_W = SET_W_DEFAULT,
    localparam int SL_W  = $clog2(SLOTS + 1),
    localparam int IDX_W = $clog2(Q * SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SET_W-1:0] wr_set,
    input  logic [SL_W-1:0]  wr_slot,
    input  logic [SET_W-1:0] wr_data,
    input  logic [SET_W-1:0] rd_set,
    input  logic [SL_W-1:0]  rd_slot,
    output logic [SET_W-1:0] rd_data
);

    logic [SET_W-1:0] mem [Q*SLOTS];
    logic             wr_ok;
    logic             rd_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Range-check both ports and flatten (set, slot) into a row-major index
    always_comb begin
        wr_ok  = set_in_range(32'(wr_set), Q) && (wr_slot != '0) && (32'(wr_slot) <= SLOTS);
        rd_ok  = set_in_range(32'(rd_set), Q) && (rd_slot != '0) && (32'(rd_slot) <= SLOTS);
        wr_idx = IDX_W'((32'(wr_set) - 1) * SLOTS + 32'(wr_slot) - 1);
        rd_idx = IDX_W'((32'(rd_set) - 1) * SLOTS + 32'(rd_slot) - 1);
        rd_data = rd_ok ? mem[rd_idx] : '0;
    end

    // Key storage: cleared by reset, written one entry per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q * SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/exam_answer_evaluator.sv
// Scores one row of (set, answer) beats per student against the answer key
// and emits one record per student. Optional macro EVAL_CLASS_TOTAL_EN adds
// class_total / err_count accumulators over a pass.
//
// Handshakes: a beat transfers on a rising edge where ans_valid && ans_ready;
// a record transfers on a rising edge where res_valid && res_ready. Once
// res_valid rises, the record fields hold until that transfer.
module exam_answer_evaluator
    import exam_eval_pkg::*;
#(
    parameter int S     = 5,
    parameter int Q     = 3,
    parameter int SLOTS = 3,
    parameter int SET_W = SET_W_DEFAULT,
    localparam int ST_W  = $clog2(S + 1),
    localparam int SL_W  = $clog2(SLOTS + 1),
    localparam int TOT_W = $clog2(S * SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             key_wr,
    input  logic [SET_W-1:0] key_set,
    input  logic [SL_W-1:0]  key_slot,
    input  logic [SET_W-1:0] key_ans,
    input  logic             ans_valid,
    output logic             ans_ready,
    input  logic [SET_W-1:0] ans_set,
    input  logic [SET_W-1:0] ans_data,
    input  logic             ans_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ST_W-1:0]  res_student,
    output logic [SL_W-1:0]  res_score,
    output logic             res_err,
    output logic             done,
`ifdef EVAL_CLASS_TOTAL_EN
    output logic [TOT_W-1:0] class_total,
    output logic [ST_W-1:0]  err_count,
`endif
    output state_t           dbg_state
);

    state_t                  state;
    state_t                  next_state;
    logic [SL_W-1:0]         slot;
    logic [ST_W-1:0]         student;
    logic [SL_W-1:0]         score;
    logic                    err;
    logic [2**SET_W-1:0]     seen;
    logic [SET_W-1:0]        key_rd;
    logic                    beat;
    logic                    in_range;
    logic                    hit;
    logic                    last_slot;
    logic                    beat_err;
    logic                    row_end;
    logic                    rec_take;
    logic                    last_student;

    exam_key_ram #(
        .Q     (Q),
        .SLOTS (SLOTS),
        .SET_W (SET_W)
    ) u_key_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (key_wr && (state == IDLE)),
        .wr_set  (key_set),
        .wr_slot (key_slot),
        .wr_data (key_ans),
        .rd_set  (ans_set),
        .rd_slot (slot),
        .rd_data (key_rd)
    );

    // Per-beat evaluation of the current (set, answer) against the key
    always_comb begin
        beat         = ans_valid && ans_ready;
        in_range     = set_in_range(32'(ans_set), Q);
        hit          = in_range && (ans_data != '0) && (ans_data == key_rd);
        last_slot    = (slot == SL_W'(SLOTS));
        beat_err     = !in_range
                     || seen[ans_set]
                     || (ans_last && !last_slot)
                     || (last_slot && !ans_last);
        row_end      = ans_last || last_slot;
        rec_take     = res_valid && res_ready;
        last_student = (student == ST_W'(S));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        ans_ready  = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = COLLECT;
            end
            COLLECT: begin
                ans_ready = 1'b1;
                if (ans_valid && row_end) next_state = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) next_state = last_student ? DONE : COLLECT;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Row accumulation and student/slot counters
    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= SL_W'(1);
            student <= ST_W'(1);
            score   <= '0;
            err     <= 1'b0;
            seen    <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (beat) begin
                        score         <= score + SL_W'(hit);
                        err           <= err | beat_err;
                        seen[ans_set] <= 1'b1;
                        if (!row_end) slot <= slot + SL_W'(1);
                    end
                end
                RESULT: begin
                    if (rec_take) begin
                        score <= '0;
                        err   <= 1'b0;
                        seen  <= '0;
                        slot  <= SL_W'(1);
                        if (!last_student) student <= student + ST_W'(1);
                    end
                end
                DONE: begin
                    student <= ST_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Record fields are only presented while a record is offered
    always_comb begin
        res_student = (state == RESULT) ? student : '0;
        res_score   = (state == RESULT) ? score : '0;
        res_err     = (state == RESULT) ? err : 1'b0;
        dbg_state   = state;
    end

`ifdef EVAL_CLASS_TOTAL_EN
    // Pass-wide totals over accepted records, cleared when a pass starts
    always_ff @(posedge clk) begin
        if (rst) begin
            class_total <= '0;
            err_count   <= '0;
        end else if ((state == IDLE) && start) begin
            class_total <= '0;
            err_count   <= '0;
        end else if (rec_take) begin
            class_total <= class_total + TOT_W'(score);
            err_count   <= err_count + ST_W'(err);
        end
    end
`endif

endmodule

// File: tb/tb_exam_answer_evaluator.sv
// Directed bench for exam_answer_evaluator with an expected-record queue.
module tb_exam_answer_evaluator;
    import exam_eval_pkg::*;

    localparam int S     = 5;
    localparam int Q     = 3;
    localparam int SLOTS = 3;
    localparam int SET_W = 3;
    localparam int ST_W  = $clog2(S + 1);
    localparam int SL_W  = $clog2(SLOTS + 1);
    localparam int TOT_W = $clog2(S * SLOTS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             key_wr;
    logic [SET_W-1:0] key_set;
    logic [SL_W-1:0]  key_slot;
    logic [SET_W-1:0] key_ans;
    logic             ans_valid;
    logic             ans_ready;
    logic [SET_W-1:0] ans_set;
    logic [SET_W-1:0] ans_data;
    logic             ans_last;
    logic             res_valid;
    logic             res_ready;
    logic [ST_W-1:0]  res_student;
    logic [SL_W-1:0]  res_score;
    logic             res_err;
    logic             done;
`ifdef EVAL_CLASS_TOTAL_EN
    logic [TOT_W-1:0] class_total;
    logic [ST_W-1:0]  err_count;
`endif
    state_t           dbg_state;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    exam_answer_evaluator #(
        .S(S), .Q(Q), .SLOTS(SLOTS), .SET_W(SET_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_wr      (key_wr),
        .key_set     (key_set),
        .key_slot    (key_slot),
        .key_ans     (key_ans),
        .ans_valid   (ans_valid),
        .ans_ready   (ans_ready),
        .ans_set     (ans_set),
        .ans_data    (ans_data),
        .ans_last    (ans_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_student (res_student),
        .res_score   (res_score),
        .res_err     (res_err),
        .done        (done),
`ifdef EVAL_CLASS_TOTAL_EN
        .class_total (class_total),
        .err_count   (err_count),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver: one key entry
    task automatic key_write(input int set, input int slot, input int ans);
        key_wr   = 1'b1;
        key_set  = SET_W'(set);
        key_slot = SL_W'(slot);
        key_ans  = SET_W'(ans);
        tick();
        key_wr   = 1'b0;
    endtask

    task automatic load_key();
        key_write(1, 1, 1); key_write(1, 2, 2); key_write(1, 3, 3);
        key_write(2, 1, 2); key_write(2, 2, 3); key_write(2, 3, 1);
        key_write(3, 1, 3); key_write(3, 2, 1);
        key_write(0, 1, 7); key_write(4, 2, 7); key_write(1, 0, 7);
    endtask

    // Driver: one answer beat, bounded wait for acceptance
    task automatic send_beat(input int set, input int ans, input logic last);
        bit acc = 1'b0;
        ans_valid = 1'b1;
        ans_set   = SET_W'(set);
        ans_data  = SET_W'(ans);
        ans_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (ans_ready) acc = 1'b1;
            tick();
        end
        ans_valid = 1'b0;
        ans_last  = 1'b0;
        if (!acc) chk("beat_timeout", 32'(0), 32'(1));
    endtask

    task automatic push_exp(input int student, input int score, input int err);
        exp_q.push_back({3'(student), 2'(score), 1'(err)});
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard: pop the expected record and compare, optionally stalling
    task automatic take_record(input int hold);
        logic [5:0] e;
        int n = 0;
        chk("rec_latency", 32'(res_valid), 32'(1));
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            chk("rec_timeout", 32'(0), 32'(1));
            return;
        end
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'(0), 32'(1));
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(res_valid), 32'(1));
            chk("hold_ans_ready", 32'(ans_ready), 32'(0));
            chk("hold_fields", 32'({res_student, res_score, res_err}), 32'(e));
        end
        chk("rec_student", 32'(res_student), 32'(e[5:3]));
        chk("rec_score", 32'(res_score), 32'(e[2:1]));
        chk("rec_err", 32'(res_err), 32'(e[0]));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_wr = 1'b0; key_set = '0; key_slot = '0;
        key_ans = '0; ans_valid = 1'b0; ans_set = '0; ans_data = '0;
        ans_last = 1'b0; res_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_ans_ready", 32'(ans_ready), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_err", 32'(res_err), 32'(0));
        chk("rst_res_student", 32'(res_student), 32'(0));
        chk("rst_res_score", 32'(res_score), 32'(0));
        chk("rst_done", 32'(done), 32'(0));

        // Key load; final entry written in the same cycle as start
        load_key();
        key_wr = 1'b1; key_set = 3'd3; key_slot = 2'd3; key_ans = 3'd2;
        start = 1'b1;
        tick();
        key_wr = 1'b0; start = 1'b0;
        chk("start_state", 32'(dbg_state), 32'(COLLECT));
        chk("collect_ready", 32'(ans_ready), 32'(1));

        // Student 1: two hits, unanswered last slot
        send_beat(1, 1, 0); send_beat(2, 3, 0); send_beat(3, 0, 1);
        push_exp(1, 2, 0);
        take_record(0);

        // Key writes and start outside IDLE must be ignored
        key_wr = 1'b1; key_set = 3'd1; key_slot = 2'd1; key_ans = 3'd7;
        start = 1'b1;
        tick();
        key_wr = 1'b0; start = 1'b0;

        // Student 2: duplicate set 2
        send_beat(2, 2, 0); send_beat(2, 3, 0); send_beat(1, 3, 1);
        push_exp(2, 3, 1);
        take_record(0);

        // Student 3: early last
        send_beat(3, 3, 0); send_beat(1, 2, 1);
        push_exp(3, 2, 1);
        take_record(0);

        // Student 4: full marks, stalled record
        send_beat(1, 1, 0); send_beat(2, 3, 0); send_beat(3, 2, 1);
        push_exp(4, 3, 0);
        take_record(4);

        // Student 5: out-of-range set, no last on final slot, stalled record
        send_beat(4, 1, 0); send_beat(1, 2, 0); send_beat(2, 1, 0);
        push_exp(5, 2, 1);
        take_record(4);
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_state", 32'(dbg_state), 32'(DONE));
        chk("done_res_valid", 32'(res_valid), 32'(0));
        tick();
        chk("done_clear", 32'(done), 32'(0));
        chk("idle_after_done", 32'(dbg_state), 32'(IDLE));
`ifdef EVAL_CLASS_TOTAL_EN
        chk("pass1_total", 32'(class_total), 32'(12));
        chk("pass1_errs", 32'(err_count), 32'(3));
        tick(); tick();
        chk("idle_total_hold", 32'(class_total), 32'(12));
`endif

        // Reset mid-pass, then a fresh pass with a cleared key
        start_pass();
`ifdef EVAL_CLASS_TOTAL_EN
        chk("start_total_clr", 32'(class_total), 32'(0));
        chk("start_errs_clr", 32'(err_count), 32'(0));
`endif
        send_beat(1, 1, 0); send_beat(2, 3, 0); send_beat(3, 0, 1);
        push_exp(1, 2, 0);
        take_record(0);
        send_beat(1, 1, 1);
        push_exp(2, 1, 1);
        take_record(0);
        send_beat(1, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        chk("midrst_res_valid", 32'(res_valid), 32'(0));
        chk("midrst_ans_ready", 32'(ans_ready), 32'(0));
        chk("midrst_exp_q", 32'(exp_q.size()), 32'(0));
        start_pass();
        send_beat(1, 1, 0); send_beat(2, 3, 0); send_beat(3, 0, 1);
        push_exp(1, 0, 0);
        take_record(0);

`ifdef EVAL_CLASS_TOTAL_EN
        // Full pass with totals: scores 3,2,0,1,3 and one error row
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_total", 32'(class_total), 32'(0));
        load_key();
        key_write(3, 3, 2);
        start_pass();
        send_beat(1, 1, 0); send_beat(2, 3, 0); send_beat(3, 2, 1);
        push_exp(1, 3, 0);
        take_record(0);
        send_beat(1, 1, 0); send_beat(2, 3, 0); send_beat(3, 0, 1);
        push_exp(2, 2, 0);
        take_record(0);
        send_beat(1, 0, 0); send_beat(2, 0, 0); send_beat(3, 0, 1);
        push_exp(3, 0, 0);
        take_record(0);
        send_beat(1, 1, 0); send_beat(1, 0, 0); send_beat(2, 0, 1);
        push_exp(4, 1, 1);
        take_record(0);
        send_beat(2, 2, 0); send_beat(3, 1, 0); send_beat(1, 3, 1);
        push_exp(5, 3, 0);
        take_record(0);
        chk("s6_done", 32'(done), 32'(1));
        tick();
        chk("s6_total", 32'(class_total), 32'(9));
        chk("s6_errs", 32'(err_count), 32'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
